// File: rtl/decoder_index_sequencer_if.sv
// Index stream between the sequencer and the decoder stage.
interface decoder_index_sequencer_if #(parameter int IDX_W = 3);
  logic [IDX_W-1:0] idx_out;
  logic             idx_valid;
  logic             idx_ready;

  modport master (output idx_out, output idx_valid, input idx_ready);
  modport slave  (input idx_out, input idx_valid, output idx_ready);
endinterface

// File: rtl/decoder_index_sequencer.sv
// Walks an index first..last (with modulo wrap) into a decoder over a valid/ready stream.
// Optional registered one-hot output enabled by DECODER_SEQ_ONEHOT_EN.
module decoder_index_sequencer #(
  parameter int IDX_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      cont,
  input  logic [IDX_W-1:0]          first_idx,
  input  logic [IDX_W-1:0]          last_idx,
  decoder_index_sequencer_if.master dec,
  output logic                      busy,
  output logic                      done
`ifdef DECODER_SEQ_ONEHOT_EN
  ,
  output logic [(1<<IDX_W)-1:0]     onehot_out
`endif
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] first_q, last_q;
  logic             cont_q;
  logic [IDX_W-1:0] idx_nxt;
  logic             vld_nxt;
  logic             xfer, at_last;

  assign xfer    = dec.idx_valid && dec.idx_ready;
  assign at_last = (dec.idx_out == last_q);

  // Next index/valid shared by the FSM and the one-hot register so both stay aligned.
  always_comb begin
    idx_nxt = dec.idx_out;
    vld_nxt = dec.idx_valid;
    if (state == IDLE) begin
      if (start && !stop) begin
        idx_nxt = first_idx;
        vld_nxt = 1'b1;
      end
    end else if (stop) begin
      vld_nxt = 1'b0;
    end else if (xfer) begin
      if (!at_last)    idx_nxt = dec.idx_out + IDX_W'(1);
      else if (cont_q) idx_nxt = first_q;
      else             vld_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      first_q       <= '0;
      last_q        <= '0;
      cont_q        <= 1'b0;
      dec.idx_out   <= '0;
      dec.idx_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      dec.idx_out   <= idx_nxt;
      dec.idx_valid <= vld_nxt;
      done          <= 1'b0;
      case (state)
        IDLE: if (start && !stop) begin
          first_q <= first_idx;
          last_q  <= last_idx;
          cont_q  <= cont;
          busy    <= 1'b1;
          state   <= RUN;
        end
        RUN: if (stop) begin
          busy  <= 1'b0;
          state <= IDLE;
        end else if (xfer && at_last && !cont_q) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DECODER_SEQ_ONEHOT_EN
  localparam int DEC_W = 1 << IDX_W;
  logic [DEC_W-1:0] one_lsb;
  assign one_lsb = DEC_W'(1);

  always_ff @(posedge clk) begin
    if (rst) onehot_out <= '0;
    else     onehot_out <= vld_nxt ? (one_lsb << idx_nxt) : '0;
  end
`endif
endmodule

// File: tb/tb_decoder_index_sequencer.sv
// Directed vector table plus hand-written full-range sequences for decoder_index_sequencer.
module tb_decoder_index_sequencer;
  localparam int IDX_W = 3;

  logic clk = 1'b0;
  logic rst, start, stop, cont;
  logic [IDX_W-1:0] first_idx, last_idx;
  logic busy, done;
`ifdef DECODER_SEQ_ONEHOT_EN
  logic [(1<<IDX_W)-1:0] onehot_out;
`endif

  decoder_index_sequencer_if #(.IDX_W(IDX_W)) dec ();

  decoder_index_sequencer #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
    .first_idx(first_idx), .last_idx(last_idx), .dec(dec),
    .busy(busy), .done(done)
`ifdef DECODER_SEQ_ONEHOT_EN
    , .onehot_out(onehot_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, s, p, c;
    logic [2:0] f, l;
    logic       rdy;
    logic [2:0] ei;
    logic       ev, eb, ed;
  } vec_t;

  vec_t vq[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic void add(logic r, logic s, logic p, logic c, logic [2:0] f, logic [2:0] l,
                              logic rdy, logic [2:0] ei, logic ev, logic eb, logic ed);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.c = c; v.f = f; v.l = l; v.rdy = rdy;
    v.ei = ei; v.ev = ev; v.eb = eb; v.ed = ed;
    vq.push_back(v);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic s, logic p, logic c, logic [2:0] f, logic [2:0] l, logic rdy);
    rst = r; start = s; stop = p; cont = c; first_idx = f; last_idx = l; dec.idx_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(string tag, int ei, int ev, int eb, int ed);
    chk({tag, " idx"},   int'(dec.idx_out), ei);
    chk({tag, " valid"}, int'(dec.idx_valid), ev);
    chk({tag, " busy"},  int'(busy), eb);
    chk({tag, " done"},  int'(done), ed);
`ifdef DECODER_SEQ_ONEHOT_EN
    chk({tag, " onehot"}, int'(onehot_out), ev ? (1 << ei) : 0);
`endif
  endtask

  initial begin
    logic [2:0] exp_i;
    bit seen;
    //   r  s  p  c  f  l  rdy  ei ev eb ed
    add(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0); // reset
    add(0, 1, 0, 0, 2, 5, 1,   2, 1, 1, 0); // one-shot 2..5
    add(0, 0, 0, 0, 0, 0, 1,   3, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   4, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   5, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   5, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,   5, 0, 0, 0); // done is one cycle
    add(0, 1, 0, 0, 6, 1, 1,   6, 1, 1, 0); // wrap 6,7,0,1
    add(0, 0, 0, 0, 0, 0, 1,   7, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 3, 1,   0, 1, 1, 0); // backpressure 0..3
    add(0, 0, 0, 0, 0, 0, 1,   1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   2, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   3, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   3, 0, 0, 1);
    add(0, 1, 1, 0, 4, 4, 1,   3, 0, 0, 0); // stop beats start in IDLE
    add(0, 1, 0, 1, 3, 4, 1,   3, 1, 1, 0); // continuous 3,4,3,4
    add(0, 0, 0, 0, 0, 0, 1,   4, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   3, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   4, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1,   4, 0, 0, 0); // stop with transfer at 4
    add(0, 0, 0, 0, 0, 0, 1,   4, 0, 0, 0);
    add(0, 1, 0, 1, 5, 5, 1,   5, 1, 1, 0); // first==last, continuous
    add(0, 1, 0, 0, 0, 0, 1,   5, 1, 1, 0); // start and new inputs ignored in RUN
    add(0, 0, 0, 0, 0, 0, 1,   5, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0,   5, 0, 0, 0); // stop without ready
    add(0, 1, 0, 0, 7, 7, 1,   7, 1, 1, 0); // first==last, one-shot
    add(0, 0, 0, 0, 0, 0, 1,   7, 0, 0, 1);
    add(0, 1, 0, 0, 1, 6, 1,   1, 1, 1, 0); // reset mid-scan
    add(0, 0, 0, 0, 0, 0, 1,   2, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 6, 1,   1, 1, 1, 0); // clean restart
    add(0, 0, 0, 0, 0, 0, 1,   2, 1, 1, 0);

    foreach (vq[i])
      begin
        drive(vq[i].r, vq[i].s, vq[i].p, vq[i].c, vq[i].f, vq[i].l, vq[i].rdy);
        chk_outs($sformatf("v%0d", i), int'(vq[i].ei), int'(vq[i].ev), int'(vq[i].eb), int'(vq[i].ed));
      end

    // Full-range continuous loop 0..7 with ready held high: one index per cycle, wraps to first.
    drive(1, 0, 0, 0, 0, 0, 0);
    chk_outs("rst2", 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 7, 1);
    exp_i = 3'd0;
    for (int k = 0; k < 20; k++) begin
      chk_outs($sformatf("loop%0d", k), int'(exp_i), 1, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 1);
      exp_i = exp_i + 3'd1;
    end
    drive(0, 0, 1, 0, 0, 0, 1);
    chk_outs("loop_stop", int'(exp_i), 0, 0, 0);

    // One-shot 0..7; done must arrive within a bounded number of cycles.
    drive(0, 1, 0, 0, 0, 7, 1);
    exp_i = 3'd0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (done) seen = 1'b1;
      else begin
        chk($sformatf("os%0d idx", k), int'(dec.idx_out), int'(exp_i));
        exp_i = exp_i + 3'd1;
        drive(0, 0, 0, 0, 0, 0, 1);
      end
    end
    chk("os done_seen", int'(seen), 1);
    chk_outs("os_end", 7, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
